// File: rtl/cpu_pkg.sv
// Shared constants for the multicycle sequencer: FSM encodings, default sizing
// and the stage index type used by the sequencer and its skip encoder.
package cpu_pkg;

    localparam int DEF_NUM_STAGES = 5;
    localparam int DEF_TIMEOUT    = 255;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_ERROR = 2'd2;

    typedef logic [2:0] stage_idx_t;

endpackage

// File: rtl/stage_skip_encoder.sv
// Priority search for the lowest stage index above the current one whose skip
// bit is clear; o_valid low means the current stage is the last to execute.
module stage_skip_encoder
    import cpu_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES
) (
    input  stage_idx_t            i_cur,
    input  logic [NUM_STAGES-1:0] i_skip,
    output stage_idx_t            o_next,
    output logic                  o_valid
);

    // Scan from the top down so the lowest qualifying index is written last.
    always_comb begin
        o_next  = 3'd0;
        o_valid = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if ((i > int'(i_cur)) && !i_skip[i]) begin
                o_next  = stage_idx_t'(i);
                o_valid = 1'b1;
            end else begin
                o_valid = o_valid;
            end
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer: steps a one-hot stage enable through the
// stages, honours a decode-time skip mask, counts retires and traps stalls.
module multicycle_sequencer
    import cpu_pkg::*;
#(
    parameter int NUM_STAGES   = DEF_NUM_STAGES,
    parameter int DECODE_STAGE = 1,
    parameter int TIMEOUT      = DEF_TIMEOUT,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  start,
    input  logic                  halt_req,
    input  logic [NUM_STAGES-1:0] stage_ready,
    input  logic [NUM_STAGES-1:0] stage_skip,
    input  logic                  err_clear,
    output logic [NUM_STAGES-1:0] stage_go,
    output logic [2:0]            stage_idx,
    output logic                  busy,
    output logic                  retire,
    output logic [CNT_W-1:0]      instr_count,
    output logic                  timeout_err
);

    localparam int                    WAIT_W    = 16;
    localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam stage_idx_t            DEC_IDX   = stage_idx_t'(DECODE_STAGE);
    localparam logic [NUM_STAGES-1:0] GO_FIRST  = {{(NUM_STAGES-1){1'b0}}, 1'b1};
    localparam logic [NUM_STAGES-1:0] GO_NONE   = {NUM_STAGES{1'b0}};

    logic [1:0]            r_state;
    stage_idx_t            r_idx;
    logic [NUM_STAGES-1:0] r_go;
    logic                  r_busy;
    logic                  r_err;
    logic [WAIT_W-1:0]     r_wait;
    logic [NUM_STAGES-1:0] r_skip;
    logic [CNT_W-1:0]      r_count;

    logic [1:0]            w_next_state;
    stage_idx_t            w_next_idx;
    logic [NUM_STAGES-1:0] w_next_go;
    logic                  w_next_err;
    logic [WAIT_W-1:0]     w_next_wait;
    logic [NUM_STAGES-1:0] w_next_skip;
    logic                  w_retire;
    logic                  w_ready;
    logic [NUM_STAGES-1:0] w_skip_ok;
    logic [NUM_STAGES-1:0] w_mask;
    stage_idx_t            w_enc_next;
    logic                  w_enc_valid;
    logic [NUM_STAGES-1:0] w_enc_go;

    // Stages up to and including decode can never be bypassed.
    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_skip_ok
        assign w_skip_ok[g] = (g > DECODE_STAGE) ? 1'b1 : 1'b0;
    end

    assign w_ready  = stage_ready[r_idx];
    // At decode exit the live mask steers the very next step; later stages use the latched copy.
    assign w_mask   = (r_idx == DEC_IDX) ? (stage_skip & w_skip_ok) : r_skip;
    assign w_enc_go = GO_FIRST << w_enc_next;

    stage_skip_encoder #(
        .NUM_STAGES (NUM_STAGES)
    ) u_skip_enc (
        .i_cur   (r_idx),
        .i_skip  (w_mask),
        .o_next  (w_enc_next),
        .o_valid (w_enc_valid)
    );

    // Next-state and next-output decode for the IDLE/RUN/ERROR machine.
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_next_go    = r_go;
        w_next_err   = r_err;
        w_next_wait  = r_wait;
        w_next_skip  = r_skip;
        w_retire     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !r_err) begin
                    w_next_state = ST_RUN;
                    w_next_idx   = 3'd0;
                    w_next_go    = GO_FIRST;
                    w_next_wait  = {WAIT_W{1'b0}};
                end else begin
                    w_next_go    = GO_NONE;
                end
            end
            ST_RUN: begin
                if (w_ready) begin
                    w_next_wait = {WAIT_W{1'b0}};
                    if (r_idx == DEC_IDX) begin
                        w_next_skip = w_mask;
                    end else begin
                        w_next_skip = r_skip;
                    end
                    if (w_enc_valid) begin
                        w_next_idx = w_enc_next;
                        w_next_go  = w_enc_go;
                    end else begin
                        w_retire    = 1'b1;
                        w_next_skip = {NUM_STAGES{1'b0}};
                        w_next_idx  = 3'd0;
                        if (halt_req) begin
                            w_next_state = ST_IDLE;
                            w_next_go    = GO_NONE;
                        end else begin
                            w_next_go    = GO_FIRST;
                        end
                    end
                end else if (r_wait == WAIT_LAST) begin
                    // The TIMEOUT-th consecutive stall cycle traps; a ready in that cycle still wins.
                    w_next_state = ST_ERROR;
                    w_next_err   = 1'b1;
                    w_next_go    = GO_NONE;
                    w_next_idx   = 3'd0;
                    w_next_wait  = {WAIT_W{1'b0}};
                    w_next_skip  = {NUM_STAGES{1'b0}};
                end else begin
                    w_next_wait  = r_wait + 16'd1;
                end
            end
            ST_ERROR: begin
                if (err_clear) begin
                    w_next_state = ST_IDLE;
                    w_next_err   = 1'b0;
                end else begin
                    w_next_state = ST_ERROR;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_idx   = 3'd0;
                w_next_go    = GO_NONE;
                w_next_err   = 1'b0;
                w_next_wait  = {WAIT_W{1'b0}};
                w_next_skip  = {NUM_STAGES{1'b0}};
            end
        endcase
    end

    // State, registered outputs and retire counter.
    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            r_state <= ST_IDLE;
            r_idx   <= 3'd0;
            r_go    <= GO_NONE;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_wait  <= {WAIT_W{1'b0}};
            r_skip  <= {NUM_STAGES{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
            r_go    <= w_next_go;
            r_busy  <= (w_next_state == ST_RUN);
            r_err   <= w_next_err;
            r_wait  <= w_next_wait;
            r_skip  <= w_next_skip;
            if (w_retire) begin
                r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_count <= r_count;
            end
        end
    end

    assign stage_go    = r_go;
    assign stage_idx   = r_idx;
    assign busy        = r_busy;
    assign retire      = w_retire;
    assign instr_count = r_count;
    assign timeout_err = r_err;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: sequencing, skip, stall, timeout,
// async abort and counter wrap, each scenario a task with inline checks.
module tb_multicycle_sequencer;

    logic       clk;
    logic       nreset;
    logic       start;
    logic       halt_req;
    logic [4:0] stage_ready;
    logic [4:0] stage_skip;
    logic       err_clear;
    logic [4:0] stage_go;
    logic [2:0] stage_idx;
    logic       busy;
    logic       retire;
    logic [3:0] instr_count;
    logic       timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_sequencer #(
        .NUM_STAGES   (5),
        .DECODE_STAGE (1),
        .TIMEOUT      (12),
        .CNT_W        (4)
    ) dut (
        .clk         (clk),
        .nreset      (nreset),
        .start       (start),
        .halt_req    (halt_req),
        .stage_ready (stage_ready),
        .stage_skip  (stage_skip),
        .err_clear   (err_clear),
        .stage_go    (stage_go),
        .stage_idx   (stage_idx),
        .busy        (busy),
        .retire      (retire),
        .instr_count (instr_count),
        .timeout_err (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [14:0] exp_v;
        exp_v = 15'd0;
        #12;
        n_tests++;
        if ({stage_go, stage_idx, busy, retire, timeout_err, instr_count} !== exp_v) begin
            n_fail++;
            $display("FAIL reset_values got=%b exp=%b",
                     {stage_go, stage_idx, busy, retire, timeout_err, instr_count}, exp_v);
        end
        @(negedge clk);
        nreset = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({stage_go, busy, instr_count} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_idle_no_start got=%b exp=%b", {stage_go, busy, instr_count}, 10'd0);
        end
    endtask

    task automatic test_basic();
        logic [8:0] exp_v;
        stage_ready = 5'b11111;
        stage_skip  = 5'b00000;
        halt_req    = 1'b0;
        start       = 1'b1;
        tick();
        start = 1'b0;
        for (int s = 0; s < 5; s++) begin
            exp_v = {5'd1 << s, 3'(s), 1'b1};
            n_tests++;
            if ({stage_go, stage_idx, busy} !== exp_v) begin
                n_fail++;
                $display("FAIL basic_go s=%0d got=%b exp=%b", s, {stage_go, stage_idx, busy}, exp_v);
            end
            halt_req = (s == 4);
            #1;
            n_tests++;
            if (retire !== (s == 4)) begin
                n_fail++;
                $display("FAIL basic_retire s=%0d got=%b exp=%b", s, retire, (s == 4));
            end
            tick();
        end
        halt_req = 1'b0;
        n_tests++;
        if ({busy, stage_go, instr_count} !== {1'b0, 5'd0, 4'd1}) begin
            n_fail++;
            $display("FAIL basic_done got=%b exp=%b", {busy, stage_go, instr_count}, {1'b0, 5'd0, 4'd1});
        end
    endtask

    task automatic test_skip();
        int          seq [9] = '{0, 1, 2, 4, 0, 1, 2, 3, 4};
        logic [12:0] exp_v;
        logic        last;
        stage_ready = 5'b11111;
        stage_skip  = 5'b01000;
        start       = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k == 4) stage_skip = 5'b00000;
            last  = (k == 3) || (k == 8);
            exp_v = {5'd1 << seq[k], 3'(seq[k]), 1'b1, 4'((k >= 4) ? 2 : 1)};
            n_tests++;
            if ({stage_go, stage_idx, busy, instr_count} !== exp_v) begin
                n_fail++;
                $display("FAIL skip_seq k=%0d got=%b exp=%b", k, {stage_go, stage_idx, busy, instr_count}, exp_v);
            end
            halt_req = (k == 8);
            #1;
            n_tests++;
            if (retire !== last) begin
                n_fail++;
                $display("FAIL skip_retire k=%0d got=%b exp=%b", k, retire, last);
            end
            tick();
        end
        halt_req = 1'b0;
        n_tests++;
        if ({busy, instr_count} !== {1'b0, 4'd3}) begin
            n_fail++;
            $display("FAIL skip_done got=%b exp=%b", {busy, instr_count}, {1'b0, 4'd3});
        end
    endtask

    task automatic test_wait();
        stage_ready = 5'b11111;
        start       = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        stage_ready = 5'b11011;
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if ({stage_go, timeout_err, retire} !== {5'b00100, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL wait_hold i=%0d got=%b exp=%b", i, {stage_go, timeout_err, retire}, {5'b00100, 2'b00});
            end
            tick();
        end
        stage_ready = 5'b11111;
        n_tests++;
        if (stage_go !== 5'b00100) begin
            n_fail++;
            $display("FAIL wait_eleventh got=%b exp=%b", stage_go, 5'b00100);
        end
        tick();
        n_tests++;
        if ({stage_go, timeout_err} !== {5'b01000, 1'b0}) begin
            n_fail++;
            $display("FAIL wait_next got=%b exp=%b", {stage_go, timeout_err}, {5'b01000, 1'b0});
        end
        tick();
        halt_req = 1'b1;
        #1;
        n_tests++;
        if ({stage_go, retire} !== {5'b10000, 1'b1}) begin
            n_fail++;
            $display("FAIL wait_retire got=%b exp=%b", {stage_go, retire}, {5'b10000, 1'b1});
        end
        tick();
        halt_req = 1'b0;
        n_tests++;
        if ({busy, instr_count} !== {1'b0, 4'd4}) begin
            n_fail++;
            $display("FAIL wait_done got=%b exp=%b", {busy, instr_count}, {1'b0, 4'd4});
        end
    endtask

    task automatic test_timeout();
        stage_ready = 5'b11111;
        start       = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        stage_ready = 5'b11011;
        for (int i = 0; i < 12; i++) begin
            n_tests++;
            if ({stage_go, timeout_err, retire} !== {5'b00100, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL tmo_wait i=%0d got=%b exp=%b", i, {stage_go, timeout_err, retire}, {5'b00100, 2'b00});
            end
            tick();
        end
        n_tests++;
        if ({stage_go, stage_idx, busy, timeout_err, retire, instr_count} !== {5'd0, 3'd0, 1'b0, 1'b1, 1'b0, 4'd4}) begin
            n_fail++;
            $display("FAIL tmo_trap got=%b exp=%b", {stage_go, stage_idx, busy, timeout_err, retire, instr_count},
                     {5'd0, 3'd0, 1'b0, 1'b1, 1'b0, 4'd4});
        end
        stage_ready = 5'b11111;
        start       = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({stage_go, busy, timeout_err} !== {5'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL tmo_start_ignored got=%b exp=%b", {stage_go, busy, timeout_err}, {5'd0, 1'b0, 1'b1});
        end
        start     = 1'b0;
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        n_tests++;
        if ({timeout_err, busy, stage_go} !== {1'b0, 1'b0, 5'd0}) begin
            n_fail++;
            $display("FAIL tmo_clear got=%b exp=%b", {timeout_err, busy, stage_go}, 7'd0);
        end
        start = 1'b1;
        tick();
        start     = 1'b0;
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        n_tests++;
        if ({stage_go, busy, timeout_err} !== {5'b00010, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL tmo_rerun got=%b exp=%b", {stage_go, busy, timeout_err}, {5'b00010, 1'b1, 1'b0});
        end
        tick();
        tick();
        tick();
        halt_req = 1'b1;
        #1;
        n_tests++;
        if ({stage_go, retire} !== {5'b10000, 1'b1}) begin
            n_fail++;
            $display("FAIL tmo_rerun_retire got=%b exp=%b", {stage_go, retire}, {5'b10000, 1'b1});
        end
        tick();
        halt_req = 1'b0;
        n_tests++;
        if ({busy, instr_count} !== {1'b0, 4'd5}) begin
            n_fail++;
            $display("FAIL tmo_count got=%b exp=%b", {busy, instr_count}, {1'b0, 4'd5});
        end
    endtask

    task automatic test_abort();
        stage_ready = 5'b11111;
        start       = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        nreset = 1'b1;
        #1;
        n_tests++;
        if ({stage_go, stage_idx, busy, retire, timeout_err, instr_count} !== 15'd0) begin
            n_fail++;
            $display("FAIL abort_async got=%b exp=%b",
                     {stage_go, stage_idx, busy, retire, timeout_err, instr_count}, 15'd0);
        end
        #2;
        nreset = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({stage_go, busy, retire, instr_count} !== 11'd0) begin
            n_fail++;
            $display("FAIL abort_waits got=%b exp=%b", {stage_go, busy, retire, instr_count}, 11'd0);
        end
    endtask

    task automatic test_wrap();
        logic [4:0] exp_go;
        stage_ready = 5'b11111;
        stage_skip  = 5'b00000;
        start       = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < 17; r++) begin
            for (int s = 0; s < 5; s++) begin
                exp_go   = 5'd1 << s;
                halt_req = (r == 16) && (s == 4);
                n_tests++;
                if (stage_go !== exp_go) begin
                    n_fail++;
                    $display("FAIL wrap_go r=%0d s=%0d got=%b exp=%b", r, s, stage_go, exp_go);
                end
                if (s == 4) begin
                    #1;
                    n_tests++;
                    if ({retire, instr_count} !== {1'b1, 4'(r)}) begin
                        n_fail++;
                        $display("FAIL wrap_count r=%0d got=%b exp=%b", r, {retire, instr_count}, {1'b1, 4'(r)});
                    end
                end
                tick();
            end
        end
        halt_req = 1'b0;
        tick();
        n_tests++;
        if ({instr_count, busy, stage_go} !== {4'd1, 1'b0, 5'd0}) begin
            n_fail++;
            $display("FAIL wrap_final got=%b exp=%b", {instr_count, busy, stage_go}, {4'd1, 1'b0, 5'd0});
        end
    endtask

    initial begin
        nreset      = 1'b1;
        start       = 1'b0;
        halt_req    = 1'b0;
        stage_ready = 5'b00000;
        stage_skip  = 5'b00000;
        err_clear   = 1'b0;
        test_reset();
        test_basic();
        test_skip();
        test_wait();
        test_timeout();
        test_abort();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
